// File: rtl/stk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stk_pkg
// Description : Shared command and status encodings for the multi-context
//               linked-list stack.
// Revision    : 1.0 - initial release
// ============================================================================
package stk_pkg;

    // Command opcodes. Encodings 5..7 are illegal and answered with ERR.
    typedef enum logic [2:0] {
        NOP   = 3'd0,
        PUSH  = 3'd1,
        POP   = 3'd2,
        PEEK  = 3'd3,
        CLEAR = 3'd4
    } opcode_t;

    // Response status codes.
    typedef enum logic [1:0] {
        OKAY  = 2'd0,
        FULL  = 2'd1,
        EMPTY = 2'd2,
        ERR   = 2'd3
    } status_t;

endpackage
`default_nettype wire

// File: rtl/stk_mc_arb.sv
`default_nettype none
// ============================================================================
// Module      : stk_mc_arb
// Description : Round-robin arbiter. The search starts at the context after
//               the last granted one; the pointer moves only on a grant.
// Revision    : 1.0 - initial release
// ============================================================================
module stk_mc_arb #(
    parameter  int CTX_N = 4,
    localparam int IDX_W = $clog2(CTX_N)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [CTX_N-1:0] i_req,
    output logic [CTX_N-1:0] o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx
);

    // Pointer resets to the last context so context 0 is searched first.
    localparam logic [IDX_W-1:0] c_ptr_rst = IDX_W'(CTX_N - 1);
    localparam logic [IDX_W:0]   c_ctx_n   = (IDX_W + 1)'(CTX_N);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_pos;
    logic             w_found;

    // Rotating priority search: first requester found after the pointer wins.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = r_ptr;
        w_found   = 1'b0;
        w_pos     = '0;
        for (int i = 1; i <= CTX_N; i++) begin
            w_pos = {1'b0, r_ptr} + (IDX_W + 1)'(i);
            if (w_pos >= c_ctx_n) begin
                w_pos = w_pos - c_ctx_n;
            end
            if (!w_found && i_req[w_pos[IDX_W-1:0]]) begin
                w_found                 = 1'b1;
                o_gnt[w_pos[IDX_W-1:0]] = 1'b1;
                o_gnt_idx               = w_pos[IDX_W-1:0];
            end
        end
    end

    // Remember the winner so it has lowest priority next time.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_ptr <= c_ptr_rst;
        end else if (|o_gnt) begin
            r_ptr <= o_gnt_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stk_mc.sv
`default_nettype none
// ============================================================================
// Module      : stk_mc
// Description : CTX_N independent LIFO stacks sharing one pool of DEPTH
//               entries, kept as singly linked lists with a common free list.
//               One command is accepted per cycle; response one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module stk_mc
    import stk_pkg::*;
#(
    parameter  int CTX_N = 4,
    parameter  int W     = 128,
    parameter  int DEPTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic [CTX_N-1:0]            i_cmd_vld,
    input  opcode_t [CTX_N-1:0]         i_cmd_opcode,
    input  logic [CTX_N-1:0][W-1:0]     i_cmd_dat,
    output logic [CTX_N-1:0]            o_cmd_ack,
    output logic [CTX_N-1:0]            o_rsp_vld,
    output logic [W-1:0]                o_rsp_dat,
    output status_t                     o_rsp_status,
    output logic                        o_busy_r,
    output logic                        o_full_r,
    output logic [CTX_N-1:0]            o_empty_r,
    output logic [CTX_N-1:0][CNT_W-1:0] o_cnt_r,
    output logic [CNT_W-1:0]            o_free_cnt_r
);

    localparam int IDX_W = $clog2(CTX_N);

    localparam logic [0:0]       c_st_init  = 1'b0;
    localparam logic [0:0]       c_st_run   = 1'b1;
    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [PTR_W-1:0] r_init_cnt;
    logic [PTR_W-1:0] r_free_head;
    logic [PTR_W-1:0] r_head [CTX_N];
    logic [PTR_W-1:0] r_tail [CTX_N];
    logic [W-1:0]     r_data [DEPTH];
    logic [PTR_W-1:0] r_next [DEPTH];

    // ------------------------------------------------------------------
    // Arbitration: requests are masked while initialising or in reset so
    // nothing is acknowledged that would be thrown away.
    // ------------------------------------------------------------------
    logic [CTX_N-1:0] w_req;
    logic [CTX_N-1:0] w_gnt;
    logic [IDX_W-1:0] w_idx;

    assign w_req     = i_cmd_vld & {CTX_N{(r_state == c_st_run) && arst_n}};
    assign o_cmd_ack = w_gnt;

    stk_mc_arb #(
        .CTX_N (CTX_N)
    ) u_arb (
        .clk       (clk),
        .arst_n    (arst_n),
        .i_req     (w_req),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_idx)
    );

    // ------------------------------------------------------------------
    // Granted command decode
    // ------------------------------------------------------------------
    logic             w_any;
    logic             w_init;
    opcode_t          w_op;
    logic [W-1:0]     w_wdat;
    logic [PTR_W-1:0] w_head;
    logic [PTR_W-1:0] w_tail;
    logic [CNT_W-1:0] w_cnt;
    logic             w_ctx_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_do_clear;

    assign w_any       = |w_gnt;
    assign w_init      = (r_state == c_st_init);
    assign w_op        = i_cmd_opcode[w_idx];
    assign w_wdat      = i_cmd_dat[w_idx];
    assign w_head      = r_head[w_idx];
    assign w_tail      = r_tail[w_idx];
    assign w_cnt       = o_cnt_r[w_idx];
    assign w_ctx_empty = (w_cnt == '0);
    assign w_do_push   = w_any && (w_op == PUSH)  && !o_full_r;
    assign w_do_pop    = w_any && (w_op == POP)   && !w_ctx_empty;
    assign w_do_clear  = w_any && (w_op == CLEAR) && !w_ctx_empty;

    // Response selection for the granted command.
    logic         w_rsp_en;
    status_t      w_rsp_st;
    logic [W-1:0] w_rsp_dat;

    // Status/data of the response; NOP produces no strobe.
    always_comb begin
        w_rsp_en  = w_any;
        w_rsp_st  = OKAY;
        w_rsp_dat = '0;
        case (w_op)
            NOP:   w_rsp_en = 1'b0;
            PUSH:  if (o_full_r) w_rsp_st = FULL;
            POP,
            PEEK: begin
                if (w_ctx_empty) w_rsp_st  = EMPTY;
                else             w_rsp_dat = r_data[w_head];
            end
            CLEAR: w_rsp_st = OKAY;
            default: w_rsp_st = ERR;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-pointer array: at most one link rewrite per cycle.
    //   INIT  : entry i -> i+1 (last link is never followed)
    //   PUSH  : new entry -> old context head
    //   POP   : popped entry -> old free head
    //   CLEAR : context tail -> old free head (whole list spliced)
    // ------------------------------------------------------------------
    logic             w_nxt_we;
    logic [PTR_W-1:0] w_nxt_wa;
    logic [PTR_W-1:0] w_nxt_wd;

    // Choose the single link write for this cycle.
    always_comb begin
        w_nxt_we = 1'b0;
        w_nxt_wa = r_init_cnt;
        w_nxt_wd = r_init_cnt + c_ptr_one;
        if (w_init) begin
            w_nxt_we = 1'b1;
        end else if (w_do_push) begin
            w_nxt_we = 1'b1;
            w_nxt_wa = r_free_head;
            w_nxt_wd = w_head;
        end else if (w_do_pop) begin
            w_nxt_we = 1'b1;
            w_nxt_wa = w_head;
            w_nxt_wd = r_free_head;
        end else if (w_do_clear) begin
            w_nxt_we = 1'b1;
            w_nxt_wa = w_tail;
            w_nxt_wd = r_free_head;
        end
    end

    // Link storage; contents are rebuilt by INIT so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_nxt_we) begin
            r_next[w_nxt_wa] <= w_nxt_wd;
        end
    end

    // Data storage; written only by an accepted PUSH into the free head.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_data[r_free_head] <= w_wdat;
        end
    end

    // ------------------------------------------------------------------
    // Control state, list pointers, counters and registered responses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state      <= c_st_init;
            r_init_cnt   <= '0;
            r_free_head  <= '0;
            o_busy_r     <= 1'b1;
            o_full_r     <= 1'b1;
            o_free_cnt_r <= '0;
            o_rsp_vld    <= '0;
            o_rsp_dat    <= '0;
            o_rsp_status <= OKAY;
            o_empty_r    <= '1;
            o_cnt_r      <= '0;
            for (int c = 0; c < CTX_N; c++) begin
                r_head[c] <= '0;
                r_tail[c] <= '0;
            end
        end else begin
            o_rsp_vld <= '0;
            if (r_state == c_st_init) begin
                // Free list grows from entry 0 one link per cycle.
                r_init_cnt   <= r_init_cnt + c_ptr_one;
                o_free_cnt_r <= o_free_cnt_r + c_cnt_one;
                if (r_init_cnt == c_ptr_last) begin
                    r_state  <= c_st_run;
                    o_busy_r <= 1'b0;
                    o_full_r <= 1'b0;
                end
            end else begin
                if (w_rsp_en) begin
                    o_rsp_vld    <= w_gnt;
                    o_rsp_dat    <= w_rsp_dat;
                    o_rsp_status <= w_rsp_st;
                end
                if (w_do_push) begin
                    r_head[w_idx]    <= r_free_head;
                    if (w_ctx_empty) begin
                        r_tail[w_idx] <= r_free_head;
                    end
                    o_cnt_r[w_idx]   <= w_cnt + c_cnt_one;
                    o_empty_r[w_idx] <= 1'b0;
                    r_free_head      <= r_next[r_free_head];
                    o_free_cnt_r     <= o_free_cnt_r - c_cnt_one;
                    o_full_r         <= (o_free_cnt_r == c_cnt_one);
                end
                if (w_do_pop) begin
                    r_head[w_idx]    <= r_next[w_head];
                    r_free_head      <= w_head;
                    o_cnt_r[w_idx]   <= w_cnt - c_cnt_one;
                    o_empty_r[w_idx] <= (w_cnt == c_cnt_one);
                    o_free_cnt_r     <= o_free_cnt_r + c_cnt_one;
                    o_full_r         <= 1'b0;
                end
                if (w_do_clear) begin
                    // Tail link was rewritten above; head becomes free head.
                    r_free_head      <= w_head;
                    o_cnt_r[w_idx]   <= '0;
                    o_empty_r[w_idx] <= 1'b1;
                    o_free_cnt_r     <= o_free_cnt_r + w_cnt;
                    o_full_r         <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stk_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_stk_mc
// Description : Directed self-checking bench for stk_mc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stk_mc;
    import stk_pkg::*;

    localparam int CTX_N = 4;
    localparam int W     = 128;
    localparam int DEPTH = 64;
    localparam int CNT_W = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        arst_n;
    logic [CTX_N-1:0]            vld;
    opcode_t [CTX_N-1:0]         opc;
    logic [CTX_N-1:0][W-1:0]     dat;
    logic [CTX_N-1:0]            ack;
    logic [CTX_N-1:0]            rsp_vld;
    logic [W-1:0]                rsp_dat;
    status_t                     rsp_status;
    logic                        busy;
    logic                        full;
    logic [CTX_N-1:0]            empty;
    logic [CTX_N-1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0]            free_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    stk_mc #(
        .CTX_N (CTX_N),
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .i_cmd_vld    (vld),
        .i_cmd_opcode (opc),
        .i_cmd_dat    (dat),
        .o_cmd_ack    (ack),
        .o_rsp_vld    (rsp_vld),
        .o_rsp_dat    (rsp_dat),
        .o_rsp_status (rsp_status),
        .o_busy_r     (busy),
        .o_full_r     (full),
        .o_empty_r    (empty),
        .o_cnt_r      (cnt),
        .o_free_cnt_r (free_cnt)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command on ctx and check ack and the response a cycle later.
    // Entered and left one time unit after a rising edge.
    task automatic cmd(input int ctx, input opcode_t op, input logic [W-1:0] d,
                       input status_t est, input logic [W-1:0] edat);
        int n;
        n = 0;
        vld      = '0;
        vld[ctx] = 1'b1;
        opc[ctx] = op;
        dat[ctx] = d;
        #1;
        while (ack == '0 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check("ack", W'(ack), W'(1) << ctx);
        @(posedge clk); #1;
        vld = '0;
        if (op == NOP) begin
            check("nop_rsp_vld", W'(rsp_vld), '0);
        end else begin
            check("rsp_vld", W'(rsp_vld), W'(1) << ctx);
            check("rsp_st", W'(rsp_status), W'(est));
            check("rsp_dat", rsp_dat, edat);
        end
    endtask

    task automatic chk_cnt(input int ctx, input int exp);
        check($sformatf("cnt%0d", ctx), W'(cnt[ctx]), W'(exp));
    endtask

    task automatic chk_inv();
        int s;
        s = int'(free_cnt);
        for (int c = 0; c < CTX_N; c++) s += int'(cnt[c]);
        check("invariant", W'(s), W'(DEPTH));
        check("full_flag", W'(full), W'(free_cnt == '0));
    endtask

    // Reset for two edges, check reset values, then time INIT with all
    // contexts requesting to prove nothing is acknowledged meanwhile.
    task automatic do_reset();
        int               n;
        logic [CTX_N-1:0] seen;
        arst_n = 1'b0;
        vld    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", W'(busy), W'(1));
        check("rst_full", W'(full), W'(1));
        check("rst_empty", W'(empty), W'(4'hF));
        check("rst_cnt", W'(cnt), '0);
        check("rst_free", W'(free_cnt), '0);
        check("rst_rsp_vld", W'(rsp_vld), '0);
        check("rst_rsp_dat", rsp_dat, '0);
        check("rst_rsp_st", W'(rsp_status), W'(OKAY));
        arst_n = 1'b1;
        for (int c = 0; c < CTX_N; c++) opc[c] = NOP;
        vld  = '1;
        seen = '0;
        n    = 0;
        while (busy && n < 200) begin
            #1;
            seen |= ack;
            @(posedge clk); #1;
            n++;
        end
        vld = '0;
        check("init_cycles", W'(n), W'(DEPTH));
        check("init_no_ack", W'(seen), '0);
        check("init_free", W'(free_cnt), W'(DEPTH));
        check("init_full", W'(full), '0);
        check("init_empty", W'(empty), W'(4'hF));
    endtask

    initial begin
        arst_n = 1'b0;
        vld    = '0;
        dat    = '0;
        for (int c = 0; c < CTX_N; c++) opc[c] = NOP;
        @(posedge clk); #1;

        do_reset();

        // Round robin with every context pushing: grant k data = k*256 + ctx.
        vld = '1;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < CTX_N; c++) begin
                opc[c] = PUSH;
                dat[c] = W'(k * 256 + c);
            end
            #1;
            check("rr_ack", W'(ack), W'(1) << (k % 4));
            if (k > 0) check("rr_rsp", W'(rsp_vld), W'(1) << ((k - 1) % 4));
            @(posedge clk); #1;
        end
        vld = '0;
        check("rr_rsp_last", W'(rsp_vld), W'(4'h8));
        for (int c = 0; c < CTX_N; c++) chk_cnt(c, 2);
        chk_inv();

        cmd(0, POP, '0, OKAY, W'('h400));
        chk_cnt(0, 1);
        cmd(0, PEEK, '0, OKAY, W'('h000));
        for (int c = 0; c < CTX_N; c++) cmd(c, CLEAR, '0, OKAY, '0);
        check("clr_free", W'(free_cnt), W'(DEPTH));
        check("clr_empty", W'(empty), W'(4'hF));
        cmd(0, CLEAR, '0, OKAY, '0);
        check("clr_empty_free", W'(free_cnt), W'(DEPTH));
        cmd(0, PEEK, '0, EMPTY, '0);
        cmd(2, opcode_t'(3'd7), W'(5), ERR, '0);
        cmd(1, NOP, '0, OKAY, '0);
        chk_inv();

        // Back-to-back on ctx1.
        cmd(1, PUSH, W'('hA), OKAY, '0);  chk_cnt(1, 1);
        cmd(1, PUSH, W'('hB), OKAY, '0);  chk_cnt(1, 2);
        cmd(1, POP,  '0, OKAY, W'('hB));  chk_cnt(1, 1);
        cmd(1, POP,  '0, OKAY, W'('hA));  chk_cnt(1, 0);
        cmd(1, POP,  '0, EMPTY, '0);      chk_cnt(1, 0);

        // Exhaust the pool on ctx2.
        for (int i = 1; i <= DEPTH; i++) cmd(2, PUSH, W'(i), OKAY, '0);
        check("full_flag_set", W'(full), W'(1));
        check("full_free", W'(free_cnt), '0);
        chk_cnt(2, 64);
        cmd(2, PUSH, W'(999), FULL, '0);
        cmd(0, PUSH, W'(5), FULL, '0);
        chk_cnt(0, 0);
        cmd(2, PEEK, '0, OKAY, W'(64));
        chk_cnt(2, 64);
        cmd(2, POP, '0, OKAY, W'(64));
        cmd(2, POP, '0, OKAY, W'(63));
        check("pop_free", W'(free_cnt), W'(2));
        check("pop_full", W'(full), '0);
        cmd(2, CLEAR, '0, OKAY, '0);
        check("clr2_free", W'(free_cnt), W'(DEPTH));

        // Clear a populated ctx3 and refill the pool across contexts.
        for (int i = 0; i < 5; i++) cmd(3, PUSH, W'('h30 + i), OKAY, '0);
        check("c3_free", W'(free_cnt), W'(59));
        cmd(3, CLEAR, '0, OKAY, '0);
        chk_cnt(3, 0);
        check("c3_free_after", W'(free_cnt), W'(DEPTH));
        for (int i = 0; i < DEPTH; i++) cmd(i % 4, PUSH, W'('h1000 + i), OKAY, '0);
        check("refill_free", W'(free_cnt), '0);
        chk_inv();
        cmd(1, POP, '0, OKAY, W'('h103D));
        cmd(3, PEEK, '0, OKAY, W'('h103F));
        chk_inv();

        // Reset in the middle of activity.
        for (int c = 0; c < CTX_N; c++) cmd(c, CLEAR, '0, OKAY, '0);
        for (int i = 0; i < 3; i++) cmd(0, PUSH, W'(i + 7), OKAY, '0);
        chk_cnt(0, 3);
        do_reset();
        check("post_rst_cnt", W'(cnt), '0);
        cmd(0, POP, '0, EMPTY, '0);
        chk_inv();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stk_mc.md
STK_MC -- requirements
Module: stk_mc

Interface
REQ-001 SHALL have parameter CTX_N, default 4, number of independent stack contexts (2..16).
REQ-002 SHALL have parameter W, default 128, data width in bits.
REQ-003 SHALL have parameter DEPTH, default 64, shared entry pool size (power of two, >=4); PTR_W = clog2(DEPTH), CNT_W = clog2(DEPTH+1).
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: arst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: i_cmd_vld  in  CTX_N  per-context command valid; held until acked.
REQ-007 SHALL have ports: i_cmd_opcode  in  CTX_N x stk_pkg::opcode_t  per-context opcode.
REQ-008 SHALL have ports: i_cmd_dat  in  CTX_N x W  per-context push data.
REQ-009 SHALL have ports: o_cmd_ack  out  CTX_N  one-hot grant, combinational, same cycle as acceptance.
REQ-010 SHALL have ports: o_rsp_vld  out  CTX_N  one-hot response strobe, registered.
REQ-011 SHALL have ports: o_rsp_dat  out  W  response data; o_rsp_status  out  stk_pkg::status_t  response status.
REQ-012 SHALL have ports: o_busy_r  out  1  pool initialisation in progress; o_full_r  out  1  free pool exhausted.
REQ-013 SHALL have ports: o_empty_r  out  CTX_N  per-context empty; o_cnt_r  out  CTX_N x CNT_W  per-context occupancy; o_free_cnt_r  out  CNT_W  free entries.

Function
REQ-014 SHALL keep one shared data array (DEPTH x W) and next-pointer array (DEPTH x PTR_W), a free-list head, and per-context head (top), tail (bottom) and count registers.
REQ-015 SHALL, after reset, spend exactly DEPTH cycles in INIT linking entry i to i+1 into the free list, with o_busy_r=1 and o_cmd_ack=0; then enter RUN with o_busy_r=0.
REQ-016 SHALL in RUN accept at most one command per cycle, granting among asserted i_cmd_vld round-robin, starting from the context after the last granted (context 0 first after reset).
REQ-017 SHALL assert the one-hot o_rsp_vld for the granted context exactly one cycle after o_cmd_ack, for every opcode except NOP (no response).
REQ-018 PUSH SHALL take the free-list head, write data, link it above the context head, increment count; status OKAY, o_rsp_dat=0.
REQ-019 PUSH with o_full_r=1 SHALL change no state and respond FULL.
REQ-020 POP SHALL return the head entry data, move head to its next pointer, return the entry to the free list, decrement count; status OKAY.
REQ-021 PEEK SHALL return head data with status OKAY and change no state.
REQ-022 POP or PEEK on an empty context SHALL change no state and respond EMPTY with o_rsp_dat=0.
REQ-023 CLEAR SHALL splice the whole context list onto the free list in one cycle (tail.next <- free head; free head <- context head), zero count, respond OKAY; CLEAR on empty context SHALL respond OKAY with no other change.
REQ-024 An opcode outside NOP/PUSH/POP/PEEK/CLEAR SHALL be acked, change no state and respond ERR.
REQ-025 Effects of a granted command SHALL be visible to the next granted command (back-to-back PUSH/POP on one context, no bubbles).
REQ-026 Invariant SHALL hold every cycle: o_free_cnt_r + sum(o_cnt_r) = DEPTH in RUN; o_full_r = (o_free_cnt_r==0); o_empty_r[c] = (o_cnt_r[c]==0).

Reset
REQ-027 With arst_n=0 at a clk edge, SHALL set: state INIT, init counter 0, o_busy_r=1, o_rsp_vld=0, o_rsp_dat=0, o_rsp_status=OKAY, o_full_r=1, o_empty_r all 1, o_cnt_r all 0, o_free_cnt_r=0, arbiter pointer to CTX_N-1.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL discard all contexts and restart INIT; data array contents need not be reset.
REQ-029 o_free_cnt_r SHALL increment by one per INIT cycle, reaching DEPTH and clearing o_full_r on leaving INIT.

Structure
REQ-030 stk_pkg SHALL hold opcode_t (NOP, PUSH, POP, PEEK, CLEAR) and status_t (OKAY, FULL, EMPTY, ERR); parameters stay module-local.
REQ-031 Round-robin arbitration SHALL be a sub-module stk_mc_arb (CTX_N requests in, one-hot grant out, pointer update on grant).

Verification
REQ-032 Reset, idle: o_busy_r=1 for 64 cycles, then 0; o_free_cnt_r=64, o_full_r=0, no ack during INIT.
REQ-033 Ctx1 PUSH 0xA, PUSH 0xB back-to-back, POP, POP, POP -> rsp OKAY/OKAY, OKAY dat 0xB, OKAY dat 0xA, EMPTY dat 0; o_cnt_r[1] 1,2,1,0,0.
REQ-034 All four contexts hold vld PUSH for 8 cycles -> acks ctx0,1,2,3,0,1,2,3; each o_cnt_r=2.
REQ-035 Push 64 to ctx2, then 65th PUSH -> FULL, o_full_r=1; PUSH on ctx0 -> FULL; PEEK ctx2 -> last pushed value, count stays 64.
REQ-036 Ctx3 holds 5, CLEAR ctx3 -> OKAY, o_cnt_r[3]=0, o_free_cnt_r+5; then 64 more pushes across contexts succeed.
REQ-037 Reset asserted mid-sequence with ctx0 count 3 -> after 64 INIT cycles all empty, POP ctx0 -> EMPTY.
